// File: rtl/spike_frame_capture_pkg.sv
// Shared constants and FSM encoding for the spike frame capture front end.
// Optional glitch filter is selected by the SPIKE_GLITCH_FILTER_EN macro.
package spike_frame_capture_pkg;

  localparam int unsigned CH_NUM_DEF  = 18;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StSnap  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/spike_chan_sync.sv
// One spike channel: input synchroniser, optional glitch filter and rising-edge detect.
// SPIKE_GLITCH_FILTER_EN adds a FILT_LEN-sample stable-high qualifier before the edge detector.
module spike_chan_sync
  import spike_frame_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic spike_in,
  output logic rise
);

  // Edges are blanked until every flop in the path holds a real post-reset sample,
  // so a line already high at reset release is not reported as a spike.
  localparam int unsigned WARM_LEN = SYNC_STAGES + 1 + FILT_LEN;
  localparam int unsigned WARM_W   = $clog2(WARM_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;
  logic [WARM_W-1:0]      r_warm;
  logic                   w_level;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], spike_in};
    end
  end

`ifdef SPIKE_GLITCH_FILTER_EN
  localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);

  logic [FILT_W-1:0] r_filt_cnt;

  // Saturating run-length of high samples; any low sample restarts it.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_filt_cnt <= '0;
    end else if (!r_sync[SYNC_STAGES-1]) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt != FILT_W'(FILT_LEN)) begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_level = (r_filt_cnt == FILT_W'(FILT_LEN));
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_level_d <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_level_d <= w_level;
      if (r_warm != WARM_W'(WARM_LEN)) begin
        r_warm <= r_warm + 1'b1;
      end
    end
  end

  assign rise = w_level & ~r_level_d & (r_warm == WARM_W'(WARM_LEN));

endmodule

// File: rtl/spike_frame_capture.sv
// Spike front end: per-channel edge capture into sticky bits, snapshot on each frame request.
// SPIKE_GLITCH_FILTER_EN enables the per-channel glitch filter inside spike_chan_sync.
module spike_frame_capture
  import spike_frame_capture_pkg::*;
#(
  parameter int unsigned CH_NUM      = CH_NUM_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic                   capture_en,
  input  logic [CH_NUM-1:0]      spike_in,
  input  logic                   frame_req,
  output logic [CH_NUM-1:0]      frame_data,
  output logic                   frame_valid,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   evt_dropped
);

  logic [CH_NUM-1:0]      w_rise;
  logic [CH_NUM-1:0]      r_sticky;
  logic                   r_drop;
  logic [CH_NUM-1:0]      r_frame_data;
  logic                   r_evt_dropped;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  cap_state_e             r_state;
  cap_state_e             w_state_next;
  logic                   w_take;
  logic                   w_clear;
  logic                   w_new_drop;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    spike_chan_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_sync (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .spike_in  (spike_in[k]),
      .rise      (w_rise[k])
    );
  end

  assign w_take     = capture_en & frame_req & (r_state != StIdle);
  assign w_clear    = ~capture_en | (r_state == StIdle);
  assign w_new_drop = |(r_sticky & w_rise);

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        w_state_next = capture_en ? StAccum : StIdle;
      end
      StAccum, StSnap: begin
        if (!capture_en) begin
          w_state_next = StIdle;
        end else if (frame_req) begin
          w_state_next = StSnap;
        end else begin
          w_state_next = StAccum;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    frame_valid = (r_state == StSnap);
  end

  // A taken snapshot opens a fresh window; edges in the request cycle went into the snapshot.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_sticky <= '0;
      r_drop   <= 1'b0;
    end else if (w_clear || w_take) begin
      r_sticky <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_sticky <= r_sticky | w_rise;
      r_drop   <= r_drop | w_new_drop;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_frame_data  <= '0;
      r_evt_dropped <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (!capture_en) begin
      r_frame_cnt <= '0;
    end else if (w_take) begin
      r_frame_data  <= r_sticky | w_rise;
      r_evt_dropped <= r_drop | w_new_drop;
      r_frame_cnt   <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_cnt   = r_frame_cnt;
  assign evt_dropped = r_evt_dropped;

endmodule

// File: tb/tb_spike_frame_capture.sv
// Directed bench for spike_frame_capture with a sample-history reference model.
// Honours SPIKE_GLITCH_FILTER_EN for the filtered-pulse cases.
module tb_spike_frame_capture;

  localparam int CH   = 18;
  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef SPIKE_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  localparam int LAT  = SYNC + (FILT_ON ? FILT : 0);
  localparam int PW   = FILT_ON ? FILT + 1 : 2;
  localparam int WARM = SYNC + 1 + FILT;

  logic          sys_clk;
  logic          sys_reset;
  logic          capture_en;
  logic [CH-1:0] spike_in;
  logic          frame_req;
  logic [CH-1:0] frame_data;
  logic          frame_valid;
  logic [7:0]    frame_cnt;
  logic          evt_dropped;

  int total = 0;
  int bad   = 0;

  spike_frame_capture #(
    .CH_NUM      (CH),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .capture_en  (capture_en),
    .spike_in    (spike_in),
    .frame_req   (frame_req),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .evt_dropped (evt_dropped)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: raw samples per clock edge since reset release.
  logic [CH-1:0] samp[$];
  int            n         = 0;
  int            m_st      = 0;  // 0 idle, 1 accumulating, 2 snapshot cycle
  logic [CH-1:0] m_sticky  = '0;
  bit            m_drop    = 1'b0;
  logic [CH-1:0] m_data    = '0;
  bit            m_dropped = 1'b0;
  logic [7:0]    m_cnt     = '0;
  bit            m_valid   = 1'b0;
  logic [CH-1:0] m_r;
  bit            m_nd;

  function automatic logic [CH-1:0] s_at(int i);
    if (i < 1 || i > samp.size()) return '0;
    return samp[i-1];
  endfunction

  // Detector level visible after edge m.
  function automatic logic [CH-1:0] lvl(int m);
    logic [CH-1:0] v;
    if (!FILT_ON) return s_at(m - SYNC + 1);
    v = '1;
    for (int j = 1; j <= FILT; j++) v &= s_at(m - j - SYNC + 1);
    return v;
  endfunction

  function automatic logic [CH-1:0] rise_at(int m);
    if (m < WARM) return '0;
    return lvl(m) & ~lvl(m - 1);
  endfunction

  always @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      samp.delete();
      n = 0; m_st = 0; m_sticky = '0; m_drop = 1'b0;
      m_data = '0; m_dropped = 1'b0; m_cnt = '0; m_valid = 1'b0;
    end else begin
      n++;
      samp.push_back(spike_in);
      m_r  = rise_at(n - 1);
      m_nd = |(m_sticky & m_r);
      if (!capture_en) begin
        m_st = 0; m_sticky = '0; m_drop = 1'b0; m_cnt = '0; m_valid = 1'b0;
      end else if (m_st == 0) begin
        m_st = 1; m_valid = 1'b0;
      end else if (frame_req) begin
        m_data    = m_sticky | m_r;
        m_dropped = m_drop | m_nd;
        m_cnt     = m_cnt + 8'd1;
        m_sticky  = '0;
        m_drop    = 1'b0;
        m_st      = 2;
        m_valid   = 1'b1;
      end else begin
        m_drop   = m_drop | m_nd;
        m_sticky = m_sticky | m_r;
        m_st     = 1;
        m_valid  = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    chk("model frame_data", 32'(frame_data), 32'(m_data));
    chk("model frame_valid", 32'(frame_valid), 32'(m_valid));
    chk("model frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("model evt_dropped", 32'(evt_dropped), 32'(m_dropped));
  end

  task automatic tick(input int k);
    repeat (k) @(negedge sys_clk);
  endtask

  task automatic req();
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
  endtask

  initial begin
    sys_reset  = 1'b1;
    capture_en = 1'b0;
    frame_req  = 1'b0;
    spike_in   = '1;
    tick(3);
    chk("reset data", 32'(frame_data), 32'h0);
    chk("reset valid", 32'(frame_valid), 32'h0);
    chk("reset cnt", 32'(frame_cnt), 32'h0);
    chk("reset dropped", 32'(evt_dropped), 32'h0);

    // Inputs high through reset release: no edge reported.
    sys_reset  = 1'b0;
    capture_en = 1'b1;
    tick(12);
    req();
    chk("held-high data", 32'(frame_data), 32'h0);
    chk("held-high cnt", 32'(frame_cnt), 32'd1);
    chk("held-high valid", 32'(frame_valid), 32'h1);
    tick(1);
    chk("valid one cycle", 32'(frame_valid), 32'h0);
    spike_in = '0;
    tick(LAT + 3);

    // Channels 0 and 17.
    spike_in[0]  = 1'b1;
    spike_in[17] = 1'b1;
    tick(PW);
    spike_in = '0;
    tick(LAT + 3);
    req();
    chk("ch0/17 data", 32'(frame_data), 32'h20001);
    chk("ch0/17 valid", 32'(frame_valid), 32'h1);
    chk("ch0/17 dropped", 32'(evt_dropped), 32'h0);
    chk("ch0/17 cnt", 32'(frame_cnt), 32'd2);
    tick(1);
    chk("ch0/17 valid low", 32'(frame_valid), 32'h0);

    // Double spike on channel 5.
    repeat (2) begin
      spike_in[5] = 1'b1;
      tick(PW);
      spike_in[5] = 1'b0;
      tick(PW);
    end
    tick(LAT + 2);
    req();
    chk("ch5 data", 32'(frame_data), 32'h20);
    chk("ch5 dropped", 32'(evt_dropped), 32'h1);
    tick(2);
    req();
    chk("empty data", 32'(frame_data), 32'h0);
    chk("empty dropped", 32'(evt_dropped), 32'h0);

    // Edge reaching the detector in the request cycle is in this frame.
    tick(3);
    spike_in[3] = 1'b1;
    tick(LAT);
    req();
    chk("same-cycle edge", 32'(frame_data), 32'h8);
    spike_in[3] = 1'b0;
    tick(LAT + 3);

    // Edge one cycle after the request goes to the next frame.
    spike_in[3] = 1'b1;
    tick(LAT - 1);
    req();
    chk("late edge excluded", 32'(frame_data), 32'h0);
    spike_in[3] = 1'b0;
    tick(LAT + 3);
    req();
    chk("late edge next frame", 32'(frame_data), 32'h8);

    // capture_en drop with channel 2 pending and a discarded request.
    spike_in[2] = 1'b1;
    tick(PW);
    spike_in[2] = 1'b0;
    tick(LAT + 3);
    capture_en = 1'b0;
    req();
    chk("disable cnt", 32'(frame_cnt), 32'd0);
    chk("disable data held", 32'(frame_data), 32'h8);
    chk("disable no valid", 32'(frame_valid), 32'h0);
    tick(2);
    capture_en = 1'b1;
    tick(3);
    req();
    chk("reenable data", 32'(frame_data), 32'h0);
    chk("reenable cnt", 32'(frame_cnt), 32'd1);

    // Back-to-back requests; channel 1 edge lands in the first snapshot cycle.
    tick(2);
    spike_in[1] = 1'b1;
    tick(LAT - 1);
    frame_req = 1'b1;
    tick(1);
    chk("b2b first data", 32'(frame_data), 32'h0);
    chk("b2b first cnt", 32'(frame_cnt), 32'd2);
    tick(1);
    frame_req = 1'b0;
    chk("b2b second data", 32'(frame_data), 32'h2);
    chk("b2b second cnt", 32'(frame_cnt), 32'd3);
    chk("b2b second valid", 32'(frame_valid), 32'h1);
    spike_in[1] = 1'b0;
    tick(LAT + 3);

`ifdef SPIKE_GLITCH_FILTER_EN
    spike_in[4] = 1'b1;
    tick(FILT - 1);
    spike_in[4] = 1'b0;
    tick(LAT + 3);
    req();
    chk("short pulse filtered", 32'(frame_data), 32'h0);
    spike_in[4] = 1'b1;
    tick(FILT + 1);
    spike_in[4] = 1'b0;
    tick(LAT + 3);
    req();
    chk("long pulse passes", 32'(frame_data), 32'h10);
`endif

    // Reset in the middle of a window.
    spike_in[6] = 1'b1;
    tick(PW);
    spike_in[6] = 1'b0;
    tick(2);
    #1 sys_reset = 1'b1;
    #1;
    chk("midreset data", 32'(frame_data), 32'h0);
    chk("midreset cnt", 32'(frame_cnt), 32'd0);
    chk("midreset valid", 32'(frame_valid), 32'h0);
    tick(2);
    sys_reset = 1'b0;
    tick(WARM + 3);
    req();
    chk("post-reset data", 32'(frame_data), 32'h0);
    chk("post-reset cnt", 32'(frame_cnt), 32'd1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
